// File: rtl/regdst_wb_queue_if.sv
// Write-back queue bus: producer push side, register-file drain side and forwarding lookup.
// slave = queue view, master = producer/consumer view.
interface regdst_wb_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
);
    logic [2:0]                 RegDst;
    logic [ADDR_W-1:0]          rt_field;
    logic [ADDR_W-1:0]          rd_field;
    logic [ADDR_W-1:0]          alt0_field;
    logic [ADDR_W-1:0]          alt1_field;
    logic [DATA_W-1:0]          wb_data;
    logic                       push;
    logic                       full;
    logic [$clog2(DEPTH):0]     count;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       wr_ready;
    logic [ADDR_W-1:0]          fwd_addr;
    logic                       fwd_hit;
    logic [DATA_W-1:0]          fwd_data;
    logic                       sel_err;

    modport slave (
        input  RegDst, rt_field, rd_field, alt0_field, alt1_field,
        input  wb_data, push, wr_ready, fwd_addr,
        output full, count, wr_en, wr_addr, wr_data,
        output fwd_hit, fwd_data, sel_err
    );

    modport master (
        output RegDst, rt_field, rd_field, alt0_field, alt1_field,
        output wb_data, push, wr_ready, fwd_addr,
        input  full, count, wr_en, wr_addr, wr_data,
        input  fwd_hit, fwd_data, sel_err
    );
endinterface

// File: rtl/regdst_wb_queue.sv
// Destination-register resolver feeding a DEPTH-entry write-back FIFO with forwarding lookup.
// Ports: clk, reset_n (async, active-low), bus (slave: push side, wr_* drain, fwd_* lookup).
module regdst_wb_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4,
    parameter int SP_IDX = 29,
    parameter int RA_IDX = 31
) (
    input  logic clk,
    input  logic reset_n,
    regdst_wb_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] idx;
    logic              legal;
    logic              accept;
    logic              pop;
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_nxt;
    logic              full_q;
    logic              sel_err_q;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PW-1:0]     slot;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    always_comb begin
        idx   = '0;
        legal = 1'b1;
        case (bus.RegDst)
            3'b000:  idx = bus.rt_field;
            3'b001:  idx = bus.rd_field;
            3'b010:  idx = ADDR_W'(SP_IDX);
            3'b011:  idx = ADDR_W'(RA_IDX);
            3'b100:  idx = bus.alt0_field;
            3'b101:  idx = bus.alt1_field;
            default: legal = 1'b0;
        endcase
    end

    // full is registered, so a pop in a full cycle does not open a slot until the next one
    assign accept    = bus.push && !full_q && legal && (idx != '0);
    assign pop       = (count_q != '0) && bus.wr_ready;
    assign count_nxt = count_q + CW'(accept) - CW'(pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            if (accept) tail_q <= tail_q + 1'b1;
            if (pop)    head_q <= head_q + 1'b1;
            count_q   <= count_nxt;
            full_q    <= (count_nxt == CW'(DEPTH));
            sel_err_q <= bus.push && !legal;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q[tail_q] <= idx;
            data_q[tail_q] <= bus.wb_data;
        end
    end

    // Walk oldest to newest so the newest matching entry wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_q + PW'(k);
            if ((CW'(k) < count_q) && (bus.fwd_addr != '0)
                && (addr_q[slot] == bus.fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[slot];
            end
        end
    end

    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.sel_err  = sel_err_q;
    assign bus.wr_en    = (count_q != '0);
    assign bus.wr_addr  = (count_q != '0) ? addr_q[head_q] : '0;
    assign bus.wr_data  = (count_q != '0) ? data_q[head_q] : '0;
    assign bus.fwd_hit  = fwd_hit;
    assign bus.fwd_data = fwd_data;
endmodule
